// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller: RAW stalls, branch/jump redirect, memory freeze, halt latch
// and stall watchdog. Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int unsigned STALL_LIMIT = 64,
  parameter int unsigned CNT_W       = $clog2(STALL_LIMIT + 1)
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] Inst_id,
  input  logic [31:0] Inst_ex,
  input  logic [31:0] Inst_mem,
  input  logic        RWrEn_ex,
  input  logic        RWrEn_mem,
  input  logic        JMP_mem,
  input  logic        BR_mem,
  input  logic        BranchCondTrue_mem,
  input  logic        halt_wb,
  input  logic        mem_busy,
  output logic        PC_WEN,
  output logic        IFID_WEN,
  output logic        IDEX_WEN,
  output logic        EXMEM_WEN,
  output logic        MEMWB_WEN,
  output logic        IFID_flush,
  output logic        IDEX_flush,
  output logic        EXMEM_flush,
  output logic        PC_redirect,
  output logic        halted,
  output logic        stall_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_LIMIT);

  typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_FREEZE, ST_HALT} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             stall_err_q, stall_err_d;

  logic [6:0] op_id;
  logic [4:0] rs1_id, rs2_id, rd_ex, rd_mem;
  logic       uses_rs1_c, uses_rs2_c, rs1_hit_c, rs2_hit_c;
  logic       raw_c, redirect_c, act_c, act_redir_c, act_raw_c;
  logic       unused_c;

  assign op_id  = Inst_id[6:0];
  assign rs1_id = Inst_id[19:15];
  assign rs2_id = Inst_id[24:20];
  assign rd_ex  = Inst_ex[11:7];
  assign rd_mem = Inst_mem[11:7];
  assign unused_c = ^{Inst_id[31:25], Inst_id[14:12], Inst_ex[31:12], Inst_ex[6:0],
                      Inst_mem[31:12], Inst_mem[6:0]};

  // Source-operand decode and RAW detection against EX and MEM (no forwarding).
  assign uses_rs1_c = (op_id == OP_REG) || (op_id == OP_IMM) || (op_id == OP_LOAD) ||
                      (op_id == OP_STORE) || (op_id == OP_BRANCH) || (op_id == OP_JALR);
  assign uses_rs2_c = (op_id == OP_REG) || (op_id == OP_STORE) || (op_id == OP_BRANCH);
  assign rs1_hit_c  = (rs1_id != 5'd0) &&
                      ((RWrEn_ex && (rs1_id == rd_ex)) || (RWrEn_mem && (rs1_id == rd_mem)));
  assign rs2_hit_c  = (rs2_id != 5'd0) &&
                      ((RWrEn_ex && (rs2_id == rd_ex)) || (RWrEn_mem && (rs2_id == rd_mem)));
  assign raw_c      = (uses_rs1_c && rs1_hit_c) || (uses_rs2_c && rs2_hit_c);
  assign redirect_c = JMP_mem || (BR_mem && BranchCondTrue_mem);

  // Redirect/raw only take effect when not held by reset, halt or a memory freeze.
  assign act_c       = RST && (state_q != ST_HALT) && !halt_wb && !mem_busy;
  assign act_redir_c = act_c && redirect_c;
  assign act_raw_c   = act_c && raw_c && !redirect_c;

  always_comb begin
    state_d = ST_RUN;
    if (halt_wb || (state_q == ST_HALT)) begin
      state_d = ST_HALT;
    end else if (mem_busy) begin
      state_d = ST_FREEZE;
    end else if (raw_c && !redirect_c) begin
      state_d = ST_STALL;
    end

    wd_cnt_d = wd_cnt_q;
    case (state_d)
      ST_STALL, ST_FREEZE: wd_cnt_d = (wd_cnt_q == LIMIT) ? wd_cnt_q : wd_cnt_q + CNT_W'(1);
      ST_RUN:              wd_cnt_d = '0;
      default:             wd_cnt_d = wd_cnt_q;
    endcase
    stall_err_d = stall_err_q || (wd_cnt_d == LIMIT);
  end

  always_comb begin
    PC_WEN      = 1'b1;
    IFID_WEN    = 1'b1;
    IDEX_WEN    = 1'b1;
    EXMEM_WEN   = 1'b1;
    MEMWB_WEN   = 1'b1;
    IFID_flush  = 1'b0;
    IDEX_flush  = 1'b0;
    EXMEM_flush = 1'b0;
    PC_redirect = 1'b0;
    if (act_redir_c) begin
      {PC_WEN, IFID_WEN, IDEX_WEN, EXMEM_WEN, MEMWB_WEN} = 5'b00000;
      {IFID_flush, IDEX_flush, EXMEM_flush}            = 3'b111;
      PC_redirect                                      = 1'b1;
    end else if (act_raw_c) begin
      {IDEX_WEN, EXMEM_WEN, MEMWB_WEN} = 3'b000;
      IDEX_flush                       = 1'b1;
    end else if (act_c) begin
      {PC_WEN, IFID_WEN, IDEX_WEN, EXMEM_WEN, MEMWB_WEN} = 5'b00000;
    end
  end

  assign halted    = (state_q == ST_HALT);
  assign stall_err = stall_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = act_raw_c   ? stall_cnt_q + 32'd1 : stall_cnt_q;
    flush_cnt_d = act_redir_c ? flush_cnt_q + 32'd1 : flush_cnt_q;
  end

  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

  // State updates on the falling edge, in step with the stage registers.
  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_RUN;
      wd_cnt_q    <= '0;
      stall_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wd_cnt_q    <= wd_cnt_d;
      stall_err_q <= stall_err_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: behavioural model plus directed vectors.
module tb_pipeline_hazard_ctrl;
  localparam int unsigned LIMIT = 64;
  localparam logic [8:0] V_HOLD  = 9'b11111_000_0;
  localparam logic [8:0] V_REDIR = 9'b00000_111_1;
  localparam logic [8:0] V_RAW   = 9'b11000_010_0;
  localparam logic [8:0] V_RUN   = 9'b00000_000_0;
  localparam logic [31:0] ADD31 = 32'h002081B3;  // add x3,x1,x2
  localparam logic [31:0] ADDI1 = 32'h00500093;  // addi x1,x0,5
  localparam logic [31:0] ADDI2 = 32'h00100113;  // addi x2,x0,1

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic [31:0] Inst_id = '0, Inst_ex = '0, Inst_mem = '0;
  logic RWrEn_ex = 0, RWrEn_mem = 0, JMP_mem = 0, BR_mem = 0, BranchCondTrue_mem = 0;
  logic halt_wb = 0, mem_busy = 0;
  logic PC_WEN, IFID_WEN, IDEX_WEN, EXMEM_WEN, MEMWB_WEN;
  logic IFID_flush, IDEX_flush, EXMEM_flush, PC_redirect, halted, stall_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  pipeline_hazard_ctrl #(.STALL_LIMIT(LIMIT)) dut (
    .CLK(CLK), .RST(RST), .Inst_id(Inst_id), .Inst_ex(Inst_ex), .Inst_mem(Inst_mem),
    .RWrEn_ex(RWrEn_ex), .RWrEn_mem(RWrEn_mem), .JMP_mem(JMP_mem), .BR_mem(BR_mem),
    .BranchCondTrue_mem(BranchCondTrue_mem), .halt_wb(halt_wb), .mem_busy(mem_busy),
    .PC_WEN(PC_WEN), .IFID_WEN(IFID_WEN), .IDEX_WEN(IDEX_WEN), .EXMEM_WEN(EXMEM_WEN),
    .MEMWB_WEN(MEMWB_WEN), .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush),
    .EXMEM_flush(EXMEM_flush), .PC_redirect(PC_redirect), .halted(halted),
    .stall_err(stall_err)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] outs();
    return {PC_WEN, IFID_WEN, IDEX_WEN, EXMEM_WEN, MEMWB_WEN,
            IFID_flush, IDEX_flush, EXMEM_flush, PC_redirect};
  endfunction

  // ---------------- behavioural model ----------------
  bit m_halt = 0;
  int m_cnt  = 0;
  bit m_err  = 0;
  logic [31:0] m_scnt = '0, m_fcnt = '0;

  function automatic bit reads_src(input logic [31:0] ins, input int which);
    logic [6:0] op;
    op = ins[6:0];
    if (which == 1)
      return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};
    return op inside {7'b0110011, 7'b0100011, 7'b1100011};
  endfunction

  function automatic bit writer_pending(input logic [4:0] r);
    if (r == 5'd0) return 0;
    return (RWrEn_ex && r == Inst_ex[11:7]) || (RWrEn_mem && r == Inst_mem[11:7]);
  endfunction

  function automatic bit m_raw();
    return (reads_src(Inst_id, 1) && writer_pending(Inst_id[19:15])) ||
           (reads_src(Inst_id, 2) && writer_pending(Inst_id[24:20]));
  endfunction

  function automatic bit m_redir();
    return JMP_mem || (BR_mem && BranchCondTrue_mem);
  endfunction

  function automatic logic [8:0] m_outs();
    if (!RST || m_halt || halt_wb || mem_busy) return V_HOLD;
    if (m_redir()) return V_REDIR;
    if (m_raw()) return V_RAW;
    return V_RUN;
  endfunction

  always @(negedge CLK or negedge RST) begin
    if (!RST) begin
      m_halt <= 0; m_cnt <= 0; m_err <= 0; m_scnt <= '0; m_fcnt <= '0;
    end else if (m_halt || halt_wb) begin
      m_halt <= 1;
    end else begin
      if (mem_busy || (m_raw() && !m_redir())) begin
        m_cnt <= (m_cnt < LIMIT) ? m_cnt + 1 : m_cnt;
        if (m_cnt + 1 >= LIMIT) m_err <= 1;
      end else begin
        m_cnt <= 0;
      end
      if (!mem_busy && m_redir()) m_fcnt <= m_fcnt + 32'd1;
      else if (!mem_busy && m_raw()) m_scnt <= m_scnt + 32'd1;
    end
  end

  // Compare process: mid high phase, away from the falling (active) edge.
  always @(posedge CLK) begin
    #3;
    chk("model_outs", 32'(outs()), 32'(m_outs()));
    chk("model_halted", 32'(halted), 32'(m_halt));
    chk("model_stall_err", 32'(stall_err), 32'(m_err));
`ifdef HAZARD_PERF_CNT_EN
    chk("model_stall_cnt", stall_cnt, m_scnt);
    chk("model_flush_cnt", flush_cnt, m_fcnt);
`endif
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic [31:0] id, input logic [31:0] ex, input logic [31:0] mem,
                       input logic wex, input logic wmem, input logic jmp, input logic br,
                       input logic bct, input logic hlt, input logic busy);
    @(posedge CLK);
    #1;
    Inst_id = id; Inst_ex = ex; Inst_mem = mem; RWrEn_ex = wex; RWrEn_mem = wmem;
    JMP_mem = jmp; BR_mem = br; BranchCondTrue_mem = bct; halt_wb = hlt; mem_busy = busy;
  endtask

  task automatic idle();
    drive('0, '0, '0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic look();
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle(); look();
    chk("reset_hold", 32'(outs()), 32'(V_HOLD));
    chk("reset_halted", 32'(halted), 32'd0);
    RST = 1'b1;
    idle(); look();
    chk("run_idle", 32'(outs()), 32'(V_RUN));

    // RAW via EX, then via MEM, then clear
    drive(ADD31, ADDI1, '0, 1, 0, 0, 0, 0, 0, 0); look();
    chk("raw_ex", 32'(outs()), 32'(V_RAW));
    drive(ADD31, '0, ADDI1, 0, 1, 0, 0, 0, 0, 0); look();
    chk("raw_mem", 32'(outs()), 32'(V_RAW));
    drive(ADD31, '0, '0, 0, 0, 0, 0, 0, 0, 0); look();
    chk("raw_clear", 32'(outs()), 32'(V_RUN));
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_stall2", stall_cnt, 32'd2);
`endif

    // x0 destination never stalls; non-reading opcode and disabled writer never stall
    drive(32'h000001B3, 32'h00000013, '0, 1, 0, 0, 0, 0, 0, 0); look();
    chk("x0_nostall", 32'(outs()), 32'(V_RUN));
    drive(32'h000081B7, ADDI1, '0, 1, 0, 0, 0, 0, 0, 0); look();
    chk("lui_nostall", 32'(outs()), 32'(V_RUN));
    drive(ADD31, ADDI1, '0, 0, 0, 0, 0, 0, 0, 0); look();
    chk("nowr_nostall", 32'(outs()), 32'(V_RUN));
    drive(ADD31, '0, ADDI2, 0, 1, 0, 0, 0, 0, 0); look();
    chk("raw_rs2_mem", 32'(outs()), 32'(V_RAW));
    idle();

    // Branch taken overrides raw; not taken falls back to raw
    drive(ADD31, ADDI1, '0, 1, 0, 0, 1, 1, 0, 0); look();
    chk("br_taken", 32'(outs()), 32'(V_REDIR));
`ifdef HAZARD_PERF_CNT_EN
    idle(); look();
    chk("perf_flush1", flush_cnt, 32'd1);
`endif
    drive(ADD31, ADDI1, '0, 1, 0, 0, 1, 0, 0, 0); look();
    chk("br_not_taken", 32'(outs()), 32'(V_RAW));
    drive('0, '0, '0, 0, 0, 1, 0, 0, 0, 0); look();
    chk("jmp", 32'(outs()), 32'(V_REDIR));
    drive('0, '0, '0, 0, 0, 1, 1, 1, 0, 1); look();
    chk("busy_beats_redir", 32'(outs()), 32'(V_HOLD));
    idle();

    // Watchdog: 64 frozen edges
    for (int k = 1; k <= 64; k++) begin
      drive('0, '0, '0, 0, 0, 0, 0, 0, 0, 1); look();
      if (k == 64) chk("wd_not_yet", 32'(stall_err), 32'd0);
    end
    idle(); look();
    chk("wd_tripped", 32'(stall_err), 32'd1);
    idle(); look();
    chk("wd_sticky", 32'(stall_err), 32'd1);
    @(posedge CLK); #1; RST = 1'b0; #1;
    chk("wd_rst_clear", 32'(stall_err), 32'd0);
    chk("rst_async_hold", 32'(outs()), 32'(V_HOLD));
    @(posedge CLK); #1; RST = 1'b1;
    idle();

    // Halt wins over redirect and latches
    drive('0, '0, '0, 0, 0, 0, 1, 1, 1, 0); look();
    chk("halt_beats_redir", 32'(outs()), 32'(V_HOLD));
    idle(); look();
    chk("halted_set", 32'(halted), 32'd1);
    drive(ADD31, ADDI1, '0, 1, 0, 1, 0, 0, 0, 0); look();
    chk("halt_hold", 32'(outs()), 32'(V_HOLD));
    @(posedge CLK); #1; RST = 1'b0; #1;
    chk("halt_rst_async", 32'(halted), 32'd0);
    @(posedge CLK); #1; RST = 1'b1;
    idle(); look();
    chk("after_halt_run", 32'(outs()), 32'(V_RUN));
    idle();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
